reg_file_rename: RTL and testbench
==================================

// Module: reg_file_rename
// PURPOSE
//  Architectural register file (x0..x31) with per-register RoB rename tags; downstream consumer of RoB issue/commit ports.
//  Decoder reads rs1/rs2 and gets either a committed value or the producing RoB id; RoB issue renames rd, RoB commit retires value.
//  Misprediction clear drops all rename tags; committed values survive. Sits between Decoder/RoB and RS/LSB operand fetch.
// PARAMETERS
//  ROB_SIZE_WIDTH   `ROB_SIZE_WIDTH (config.v, 4)   width of a RoB id
//  REG_NUM          32                               architectural register count (x0 hardwired 0)
// PORTS
//  clk             in   1    system clock; all state updates on posedge
//  rst             in   1    synchronous, active-low reset (sampled on posedge clk; 0 = reset)
//  rdy             in   1    global enable; 0 = freeze all state, outputs still combinational
//  clear           in   1    RoB flush (mispredict)
//  issue_signal    in   1    Decoder issues an instruction this cycle
//  issue_rd        in   5    destination reg of issued instr; 0 = no rename
//  issue_rob_id    in   RW   RoB slot allocated to issued instr
//  commit_rd       in   5    destination reg of committing instr; 0 = no write
//  commit_rob_id   in   RW   RoB slot committing
//  commit_value    in   32   value being committed
//  rs1, rs2        in   5    source register indices from Decoder
//  rs1_value/rs2_value  out  32  committed value (valid when busy=0)
//  rs1_busy/rs2_busy    out  1   operand still pending in RoB
//  rs1_rob_id/rs2_rob_id out RW  producing RoB id (valid when busy=1, else 0)
// BEHAVIOUR
//  State: value[32] x32b, busy[32] x1b, tag[32] x RW. Reset (rst==0 at posedge): all value/busy/tag = 0.
//  Priority per posedge: !rst > !rdy(hold) > normal update. Reset mid-operation discards all tags and values.
//  Commit (commit_rd!=0): value[commit_rd] <= commit_value unconditionally (in-order retire);
//   busy[commit_rd] <= 0 only if tag[commit_rd]==commit_rob_id (no younger renamer).
//  Issue (issue_signal && issue_rd!=0 && !clear): busy[issue_rd] <= 1, tag[issue_rd] <= issue_rob_id.
//  Same-cycle issue+commit to same rd: value written, issue wins busy/tag (busy=1, tag=issue_rob_id).
//  clear: all busy <= 0, tags <= 0; same-cycle commit value still written; same-cycle issue ignored.
//  x0: never written, never busy; reads of x0 return value=0, busy=0, rob_id=0 regardless of inputs.
//  Read (combinational, zero latency), per port rsN:
//   - busy[rsN] && commit_rd==rsN && tag[rsN]==commit_rob_id && rdy -> value=commit_value, busy=0 (commit bypass).
//   - else busy[rsN] -> busy=1, rob_id=tag[rsN], value=value[rsN].
//   - else busy=0, value=value[rsN], rob_id=0.
//   Reads see pre-issue state: an instr issued this cycle never depends on its own rd rename.
//  No wrap-around logic needed: RoB guarantees tag uniqueness among in-flight entries.
//  !rdy: no state change, commit bypass disabled.
// STRUCTURE
//  Constants ROB_SIZE_WIDTH, REG_NUM belong in shared config.v; no new typedefs.
//  Flat module: one posedge always block for state, two identical read-port lookups
//  (a function read_port(idx) is the natural factoring; no sub-module).
// TESTING
//  Reset: rst=0 one cycle -> all 32 reads give value=0,busy=0,rob_id=0.
//  Issue x5 tag 3, next cycle read rs1=5 -> busy=1,rob_id=3; commit x5 tag 3 val 0xDEAD -> same-cycle read busy=0,value=0xDEAD; next cycle stored.
//  Rename chain: issue x7 tag1, then x7 tag2; commit x7 tag1 val 11 -> value=11, busy=1, rob_id=2; commit tag2 val 22 -> busy=0,value=22.
//  Same-cycle issue x9 tag4 + commit x9 tag4 val 5 -> after edge busy=1,tag=4,value=5.
//  clear with x3 busy tag6, x4 busy tag7, commit x3 tag6 val 8 same cycle -> all busy=0, value[x3]=8, issue that cycle dropped.
//  x0: issue rd=0 and commit rd=0 val 0xFFFF -> read x0 gives 0,busy=0; rdy=0 during commit -> no state change.

Source files
------------

// File: rtl/reg_file_rename_pkg.sv
// Shared sizing constants and the read-port result record for the renaming register file.
package reg_file_rename_pkg;

  localparam int unsigned RobSizeWidth = 4;
  localparam int unsigned RegNum       = 32;
  localparam int unsigned RegIdxWidth  = $clog2(RegNum);

  typedef struct packed {
    logic [31:0]             value;
    logic                    busy;
    logic [RobSizeWidth-1:0] rob_id;
  } read_res_t;

endpackage

// File: rtl/reg_file_rename.sv
// Architectural register file x0..x31 with per-register RoB rename tags.
// Reads return either the committed value or the producing RoB id, with same-cycle commit bypass.
module reg_file_rename
  import reg_file_rename_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    clear,
  input  logic                    issue_signal,
  input  logic [RegIdxWidth-1:0]  issue_rd,
  input  logic [RobSizeWidth-1:0] issue_rob_id,
  input  logic [RegIdxWidth-1:0]  commit_rd,
  input  logic [RobSizeWidth-1:0] commit_rob_id,
  input  logic [31:0]             commit_value,
  input  logic [RegIdxWidth-1:0]  rs1,
  input  logic [RegIdxWidth-1:0]  rs2,
  output logic [31:0]             rs1_value,
  output logic                    rs1_busy,
  output logic [RobSizeWidth-1:0] rs1_rob_id,
  output logic [31:0]             rs2_value,
  output logic                    rs2_busy,
  output logic [RobSizeWidth-1:0] rs2_rob_id
);

  logic [31:0]             value_q [RegNum];
  logic [RegNum-1:0]       busy_q;
  logic [RobSizeWidth-1:0] tag_q   [RegNum];

  // Issue is written after commit so a same-cycle rename of the same rd wins busy/tag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
      for (int i = 0; i < RegNum; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else if (rdy) begin
      if (commit_rd != '0) begin
        value_q[commit_rd] <= commit_value;
        if (tag_q[commit_rd] == commit_rob_id) begin
          busy_q[commit_rd] <= 1'b0;
        end
      end
      if (clear) begin
        busy_q <= '0;
        for (int i = 0; i < RegNum; i++) begin
          tag_q[i] <= '0;
        end
      end else if (issue_signal && issue_rd != '0) begin
        busy_q[issue_rd] <= 1'b1;
        tag_q[issue_rd]  <= issue_rob_id;
      end
    end
  end

  function automatic read_res_t read_port(input logic [RegIdxWidth-1:0] idx);
    read_res_t res;
    res = '0;
    if (idx == '0) begin
      res = '0;
    end else if (busy_q[idx] && rdy && commit_rd == idx && tag_q[idx] == commit_rob_id) begin
      res.value = commit_value;
    end else begin
      res.value  = value_q[idx];
      res.busy   = busy_q[idx];
      res.rob_id = busy_q[idx] ? tag_q[idx] : '0;
    end
    return res;
  endfunction

  read_res_t rd1, rd2;

  always_comb begin
    rd1 = read_port(rs1);
    rd2 = read_port(rs2);
  end

  assign rs1_value  = rd1.value;
  assign rs1_busy   = rd1.busy;
  assign rs1_rob_id = rd1.rob_id;
  assign rs2_value  = rd2.value;
  assign rs2_busy   = rd2.busy;
  assign rs2_rob_id = rd2.rob_id;

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed bench for reg_file_rename: a register-level model checked every cycle, plus literal pins.
module tb_reg_file_rename;
  import reg_file_rename_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst, rdy, clear, issue_signal;
  logic [RegIdxWidth-1:0]  issue_rd, commit_rd, rs1, rs2;
  logic [RobSizeWidth-1:0] issue_rob_id, commit_rob_id;
  logic [31:0]             commit_value;
  logic [31:0]             rs1_value, rs2_value;
  logic                    rs1_busy, rs2_busy;
  logic [RobSizeWidth-1:0] rs1_rob_id, rs2_rob_id;

  reg_file_rename dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .clear        (clear),
    .issue_signal (issue_signal),
    .issue_rd     (issue_rd),
    .issue_rob_id (issue_rob_id),
    .commit_rd    (commit_rd),
    .commit_rob_id(commit_rob_id),
    .commit_value (commit_value),
    .rs1          (rs1),
    .rs2          (rs2),
    .rs1_value    (rs1_value),
    .rs1_busy     (rs1_busy),
    .rs1_rob_id   (rs1_rob_id),
    .rs2_value    (rs2_value),
    .rs2_busy     (rs2_busy),
    .rs2_rob_id   (rs2_rob_id)
  );

  always #5 clk = ~clk;

  // Model: committed value, pending flag and producer tag per register.
  logic [31:0]             m_val  [RegNum];
  logic                    m_busy [RegNum];
  logic [RobSizeWidth-1:0] m_tag  [RegNum];
  logic                    model_ok = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < RegNum; i++) begin
        m_val[i]  <= 32'd0;
        m_busy[i] <= 1'b0;
        m_tag[i]  <= '0;
      end
      model_ok <= 1'b1;
    end else if (rdy) begin
      if (commit_rd != 0) begin
        m_val[commit_rd] <= commit_value;
        if (m_tag[commit_rd] == commit_rob_id) m_busy[commit_rd] <= 1'b0;
      end
      if (clear) begin
        for (int i = 0; i < RegNum; i++) begin
          m_busy[i] <= 1'b0;
          m_tag[i]  <= '0;
        end
      end else if (issue_signal && issue_rd != 0) begin
        m_busy[issue_rd] <= 1'b1;
        m_tag[issue_rd]  <= issue_rob_id;
      end
    end
  end

  function automatic logic [36:0] model_read(input int idx);
    logic [31:0]             v;
    logic                    b;
    logic [RobSizeWidth-1:0] t;
    v = 32'd0; b = 1'b0; t = '0;
    if (idx == 0) begin
      v = 32'd0;
    end else if (m_busy[idx] && rdy && int'(commit_rd) == idx && m_tag[idx] == commit_rob_id) begin
      v = commit_value;
    end else if (m_busy[idx]) begin
      v = m_val[idx]; b = 1'b1; t = m_tag[idx];
    end else begin
      v = m_val[idx];
    end
    return {v, b, t};
  endfunction

  // Hand-computed expectations, set by the stimulus and checked at the next falling edge.
  logic        lit1_en = 1'b0, lit2_en = 1'b0;
  string       lit1_name, lit2_name;
  logic [36:0] lit1_exp, lit2_exp;

  int n_checks = 0;
  int n_fail   = 0;

  always @(negedge clk) begin
    logic [36:0] got1, got2, e1, e2;
    got1 = {rs1_value, rs1_busy, rs1_rob_id};
    got2 = {rs2_value, rs2_busy, rs2_rob_id};
    if (model_ok && rst) begin
      e1 = model_read(int'(rs1));
      e2 = model_read(int'(rs2));
      n_checks++;
      if (got1 !== e1) begin
        n_fail++;
        $display("FAIL model_rs1 t=%0t rs1=%0d got val=%h busy=%b id=%0d want val=%h busy=%b id=%0d",
                 $time, rs1, got1[36:5], got1[4], got1[3:0], e1[36:5], e1[4], e1[3:0]);
      end
      n_checks++;
      if (got2 !== e2) begin
        n_fail++;
        $display("FAIL model_rs2 t=%0t rs2=%0d got val=%h busy=%b id=%0d want val=%h busy=%b id=%0d",
                 $time, rs2, got2[36:5], got2[4], got2[3:0], e2[36:5], e2[4], e2[3:0]);
      end
    end
    if (lit1_en) begin
      n_checks++;
      if (got1 !== lit1_exp) begin
        n_fail++;
        $display("FAIL %s rs1 got val=%h busy=%b id=%0d want val=%h busy=%b id=%0d", lit1_name,
                 got1[36:5], got1[4], got1[3:0], lit1_exp[36:5], lit1_exp[4], lit1_exp[3:0]);
      end
    end
    if (lit2_en) begin
      n_checks++;
      if (got2 !== lit2_exp) begin
        n_fail++;
        $display("FAIL %s rs2 got val=%h busy=%b id=%0d want val=%h busy=%b id=%0d", lit2_name,
                 got2[36:5], got2[4], got2[3:0], lit2_exp[36:5], lit2_exp[4], lit2_exp[3:0]);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    lit1_en      = 1'b0;
    lit2_en      = 1'b0;
    rst          = 1'b1;
    rdy          = 1'b1;
    clear        = 1'b0;
    issue_signal = 1'b0;
    issue_rd     = '0;
    issue_rob_id = '0;
    commit_rd    = '0;
    commit_rob_id = '0;
    commit_value = 32'd0;
  endtask

  task automatic expect1(input string name, input logic [31:0] v, input logic b,
                         input logic [RobSizeWidth-1:0] t);
    lit1_name = name; lit1_exp = {v, b, t}; lit1_en = 1'b1;
  endtask

  task automatic expect2(input string name, input logic [31:0] v, input logic b,
                         input logic [RobSizeWidth-1:0] t);
    lit2_name = name; lit2_exp = {v, b, t}; lit2_en = 1'b1;
  endtask

  task automatic issue(input int rd, input int id);
    issue_signal = 1'b1; issue_rd = rd[4:0]; issue_rob_id = id[3:0];
  endtask

  task automatic commit(input int rd, input int id, input logic [31:0] v);
    commit_rd = rd[4:0]; commit_rob_id = id[3:0]; commit_value = v;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; clear = 1'b0; issue_signal = 1'b0;
    issue_rd = '0; issue_rob_id = '0; commit_rd = '0; commit_rob_id = '0;
    commit_value = 32'd0; rs1 = '0; rs2 = '0;

    // Reset, then sweep every register on both ports.
    next_cycle();
    for (int i = 0; i < RegNum; i++) begin
      rs1 = i[4:0]; rs2 = 5'(31 - i);
      expect1("reset_sweep", 32'd0, 1'b0, 4'd0);
      expect2("reset_sweep", 32'd0, 1'b0, 4'd0);
      next_cycle();
    end

    // Rename x5 then retire it with bypass.
    issue(5, 3); rs1 = 5'd5;
    expect1("read_own_issue_cycle", 32'd0, 1'b0, 4'd0);
    next_cycle();
    expect1("x5_renamed", 32'd0, 1'b1, 4'd3);
    next_cycle();
    commit(5, 3, 32'hDEAD);
    expect1("x5_commit_bypass", 32'hDEAD, 1'b0, 4'd0);
    next_cycle();
    expect1("x5_stored", 32'hDEAD, 1'b0, 4'd0);

    // Rename chain on x7.
    next_cycle(); issue(7, 1); rs1 = 5'd7;
    next_cycle(); issue(7, 2);
    expect1("x7_first_tag", 32'd0, 1'b1, 4'd1);
    next_cycle(); commit(7, 1, 32'd11);
    expect1("x7_stale_commit_no_bypass", 32'd0, 1'b1, 4'd2);
    next_cycle();
    expect1("x7_old_commit_stays_busy", 32'd11, 1'b1, 4'd2);
    next_cycle(); commit(7, 2, 32'd22);
    expect1("x7_final_bypass", 32'd22, 1'b0, 4'd0);
    next_cycle();
    expect1("x7_final", 32'd22, 1'b0, 4'd0);

    // Same-cycle issue and commit on x9.
    next_cycle(); issue(9, 4); commit(9, 4, 32'd5); rs1 = 5'd9;
    next_cycle();
    expect1("x9_issue_wins", 32'd5, 1'b1, 4'd4);

    // Flush with pending renames, a same-cycle commit and a dropped issue.
    next_cycle(); issue(3, 6);
    next_cycle(); issue(4, 7); rs1 = 5'd3; rs2 = 5'd4;
    expect1("x3_busy", 32'd0, 1'b1, 4'd6);
    next_cycle(); clear = 1'b1; commit(3, 6, 32'd8); issue(10, 9);
    expect2("x4_busy_before_clear", 32'd0, 1'b1, 4'd7);
    next_cycle();
    expect1("x3_after_clear", 32'd8, 1'b0, 4'd0);
    expect2("x4_after_clear", 32'd0, 1'b0, 4'd0);
    next_cycle(); rs1 = 5'd10; rs2 = 5'd9;
    expect1("x10_issue_dropped", 32'd0, 1'b0, 4'd0);
    expect2("x9_cleared", 32'd5, 1'b0, 4'd0);

    // x0 is never written or renamed.
    next_cycle(); issue(0, 5); commit(0, 5, 32'hFFFF); rs1 = 5'd0; rs2 = 5'd0;
    expect1("x0_during_write", 32'd0, 1'b0, 4'd0);
    next_cycle();
    expect1("x0_after_write", 32'd0, 1'b0, 4'd0);

    // Frozen cycle: no bypass, no state change.
    next_cycle(); issue(12, 8); rs1 = 5'd12; rs2 = 5'd13;
    next_cycle(); rdy = 1'b0; commit(12, 8, 32'h1234); issue(13, 2);
    expect1("x12_no_bypass_when_frozen", 32'd0, 1'b1, 4'd8);
    next_cycle();
    expect1("x12_frozen_commit_lost", 32'd0, 1'b1, 4'd8);
    expect2("x13_frozen_issue_lost", 32'd0, 1'b0, 4'd0);

    // Reset mid-operation wipes values and tags.
    next_cycle(); rst = 1'b0; rs1 = 5'd5;
    next_cycle(); rs2 = 5'd12;
    expect1("x5_after_reset", 32'd0, 1'b0, 4'd0);
    expect2("x12_after_reset", 32'd0, 1'b0, 4'd0);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
